// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/HALT sequencer for an 8-bit core.
//            Optional macro CTRL_SINGLE_STEP_EN adds a step input that gates
//            each fetch to one rising edge of step.
// Revision : 1.0  initial release
// ============================================================================
module control_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pause,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic        step,
`endif
   output logic        imem_req,
   output logic [7:0]  imem_addr,
   input  logic [15:0] imem_data,
   input  logic        imem_ready,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [7:0]  dmem_addr,
   output logic [7:0]  dmem_wdata,
   input  logic        dmem_ready,
   input  logic [7:0]  read_a,
   input  logic [7:0]  read_b,
   input  logic        alu_zero,
   input  logic        alu_carry,
   output logic        write_alu,
   output logic        is_load,
   output logic        imm_flag,
   output logic        write_en,
   output logic        cpu_paused,
   output logic [2:0]  alu_opcode,
   output logic [7:0]  imm_data,
   output logic [3:0]  write_addr,
   output logic [3:0]  ra_addr,
   output logic [3:0]  rb_addr,
   output logic [7:0]  pc,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_pc, w_pc_nxt, w_pc_inc;
   logic [15:0] r_ir, w_ir_nxt;
   logic        r_z, w_z_nxt;
   logic        r_c, w_c_nxt;
   logic        w_step_ok;
   logic        w_fetch_ok;
   logic [3:0]  w_op;
   logic [3:0]  w_rd;
   logic [7:0]  w_imm8;

   assign w_op     = r_ir[15:12];
   assign w_rd     = r_ir[11:8];
   assign w_imm8   = r_ir[7:0];
   assign w_pc_inc = r_pc + 8'd1;
   assign pc       = r_pc;

`ifdef CTRL_SINGLE_STEP_EN
   // A step edge arms one fetch; the arm is consumed when the IR is latched.
   logic r_step_d, r_step_pend;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_step_d    <= 1'b0;
         r_step_pend <= 1'b0;
      end else begin
         r_step_d <= step;
         if (r_state == S_FETCH && w_fetch_ok && imem_ready)
            r_step_pend <= 1'b0;
         else if (step && !r_step_d)
            r_step_pend <= 1'b1;
      end
   end
   assign w_step_ok = r_step_pend;
`else
   assign w_step_ok = 1'b1;
`endif

   assign w_fetch_ok = !pause && w_step_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_pc    <= 8'd0;
         r_ir    <= 16'd0;
         r_z     <= 1'b0;
         r_c     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_ir    <= w_ir_nxt;
         r_z     <= w_z_nxt;
         r_c     <= w_c_nxt;
      end
   end

   // Outputs are gated by rst_n so reset clears them without waiting for a clock.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ir_nxt    = r_ir;
      w_z_nxt     = r_z;
      w_c_nxt     = r_c;
      imem_req    = 1'b0;
      imem_addr   = 8'd0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      dmem_addr   = 8'd0;
      dmem_wdata  = 8'd0;
      write_alu   = 1'b0;
      is_load     = 1'b0;
      imm_flag    = 1'b0;
      write_en    = 1'b0;
      cpu_paused  = 1'b0;
      alu_opcode  = 3'd0;
      imm_data    = 8'd0;
      write_addr  = 4'd0;
      ra_addr     = 4'd0;
      rb_addr     = 4'd0;
      halted      = 1'b0;
      if (rst_n) begin
         ra_addr = r_ir[7:4];
         rb_addr = r_ir[3:0];
         case (r_state)
            S_FETCH: begin
               if (w_fetch_ok) begin
                  imem_req  = 1'b1;
                  imem_addr = r_pc;
                  if (imem_ready) begin
                     w_ir_nxt    = imem_data;
                     w_state_nxt = S_DECODE;
                  end
               end else begin
                  cpu_paused = 1'b1;
               end
            end
            S_DECODE: w_state_nxt = S_EXEC;
            S_EXEC: begin
               w_pc_nxt    = w_pc_inc;
               w_state_nxt = S_FETCH;
               if (!w_op[3]) begin
                  write_en   = 1'b1;
                  write_alu  = 1'b1;
                  write_addr = w_rd;
                  alu_opcode = w_op[2:0];
                  w_z_nxt    = alu_zero;
                  w_c_nxt    = alu_carry;
               end else begin
                  case (w_op[2:0])
                     3'b000: begin
                        write_en   = 1'b1;
                        write_addr = w_rd;
                        imm_data   = w_imm8;
                     end
                     3'b001, 3'b010: begin
                        w_pc_nxt    = r_pc;
                        w_state_nxt = S_MEM;
                     end
                     3'b011: begin
                        write_en   = 1'b1;
                        write_alu  = 1'b1;
                        imm_flag   = 1'b1;
                        write_addr = w_rd;
                        imm_data   = {4'h0, r_ir[3:0]};
                        w_z_nxt    = alu_zero;
                        w_c_nxt    = alu_carry;
                     end
                     3'b100: w_pc_nxt = w_imm8;
                     3'b101: if (r_z) w_pc_nxt = w_imm8;
                     3'b110: if (r_c) w_pc_nxt = w_imm8;
                     default: begin
                        w_pc_nxt    = r_pc;
                        w_state_nxt = S_HALT;
                     end
                  endcase
               end
            end
            S_MEM: begin
               dmem_req  = 1'b1;
               dmem_addr = read_a;
               if (w_op[2:0] == 3'b010) begin
                  dmem_we    = 1'b1;
                  dmem_wdata = read_b;
               end else begin
                  is_load    = 1'b1;
                  write_addr = w_rd;
                  write_en   = dmem_ready;
               end
               if (dmem_ready) begin
                  w_pc_nxt    = w_pc_inc;
                  w_state_nxt = S_FETCH;
               end
            end
            S_HALT: begin
               halted     = 1'b1;
               cpu_paused = 1'b1;
            end
            default: w_state_nxt = S_FETCH;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Brief    : Directed self-checking bench for control_unit (default build).
// Revision : 1.0  initial release
// ============================================================================
module tb_control_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pause = 1'b0;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic [15:0] imem_data;
   logic        imem_ready = 1'b1;
   logic        dmem_req;
   logic        dmem_we;
   logic [7:0]  dmem_addr;
   logic [7:0]  dmem_wdata;
   logic        dmem_ready = 1'b1;
   logic [7:0]  read_a = 8'h33;
   logic [7:0]  read_b = 8'hA7;
   logic        alu_zero = 1'b1;
   logic        alu_carry = 1'b1;
   logic        write_alu, is_load, imm_flag, write_en, cpu_paused, halted;
   logic [2:0]  alu_opcode;
   logic [7:0]  imm_data, pc;
   logic [3:0]  write_addr, ra_addr, rb_addr;

   logic [15:0] imem [256];
   int          n_chk = 0;
   int          n_pass = 0;
   int          req_cycles, we_cycles, load_at_we;
   logic [7:0]  pc_after_ld;

   assign imem_data = imem[imem_addr];

   always #5 clk = ~clk;

   control_unit u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pause      (pause),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .imem_ready (imem_ready),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ready (dmem_ready),
      .read_a     (read_a),
      .read_b     (read_b),
      .alu_zero   (alu_zero),
      .alu_carry  (alu_carry),
      .write_alu  (write_alu),
      .is_load    (is_load),
      .imm_flag   (imm_flag),
      .write_en   (write_en),
      .cpu_paused (cpu_paused),
      .alu_opcode (alu_opcode),
      .imm_data   (imm_data),
      .write_addr (write_addr),
      .ra_addr    (ra_addr),
      .rb_addr    (rb_addr),
      .pc         (pc),
      .halted     (halted)
   );

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) imem[a] = 16'hF000;
      imem[8'h00] = 16'h8105;   // LDI r1,0x05
      imem[8'h01] = 16'h82FB;   // LDI r2,0xFB
      imem[8'h02] = 16'h0312;   // ADD r3,r1,r2
      imem[8'h03] = 16'hD040;   // BZ 0x40
      imem[8'h04] = 16'hF000;   // HLT
      imem[8'h40] = 16'hE050;   // BC 0x50
      imem[8'h50] = 16'h9510;   // LD r5,[r1]
      imem[8'h51] = 16'hA012;   // ST [r1],r2
      imem[8'h52] = 16'hC0FF;   // JMP 0xFF
      imem[8'hFF] = 16'h8612;   // LDI r6,0x12

      #2;
      chk("rst_imem_req", imem_req, 0);
      chk("rst_pc", pc, 0);
      chk("rst_cpu_paused", cpu_paused, 0);
      tick(1);
      rst_n = 1'b1;
      #1;
      chk("first_fetch_req", imem_req, 1);
      chk("first_fetch_addr", imem_addr, 8'h00);

      // LDI r1,0x05
      tick(1);
      chk("decode_no_we", write_en, 0);
      chk("decode_no_req", imem_req, 0);
      tick(1);
      chk("ldi_we", write_en, 1);
      chk("ldi_walu", write_alu, 0);
      chk("ldi_isload", is_load, 0);
      chk("ldi_imm", imm_data, 8'h05);
      chk("ldi_waddr", write_addr, 4'd1);
      tick(1);
      chk("ldi_next_addr", imem_addr, 8'h01);

      // LDI r2,0xFB
      tick(2);
      chk("ldi2_imm", imm_data, 8'hFB);
      tick(1);

      // ADD r3,r1,r2 with Z=C=1 from the datapath
      tick(2);
      chk("add_we", write_en, 1);
      chk("add_walu", write_alu, 1);
      chk("add_waddr", write_addr, 4'd3);
      chk("add_op", alu_opcode, 3'd0);
      chk("add_ra", ra_addr, 4'd1);
      chk("add_rb", rb_addr, 4'd2);
      chk("add_pc", pc, 8'h02);
      tick(1);
      chk("after_add_pc", pc, 8'h03);

      // BZ taken, then BC taken
      tick(3);
      chk("bz_taken_pc", pc, 8'h40);
      chk("bz_taken_addr", imem_addr, 8'h40);
      tick(3);
      chk("bc_taken_pc", pc, 8'h50);

      // LD with dmem_ready delayed three MEM cycles
      dmem_ready = 1'b0;
      tick(2);
      chk("ld_exec_no_dreq", dmem_req, 0);
      tick(1);
      req_cycles = 0;
      we_cycles = 0;
      load_at_we = 0;
      pc_after_ld = 8'h00;
      for (int i = 0; i < 6; i++) begin
         dmem_ready = (i >= 3);
         #1;
         if (dmem_req) req_cycles++;
         if (write_en) begin
            we_cycles++;
            if (is_load) load_at_we++;
         end
         if (i == 4) pc_after_ld = pc;
         tick(1);
      end
      chk("ld_req_cycles", req_cycles[7:0], 8'd4);
      chk("ld_we_cycles", we_cycles[7:0], 8'd1);
      chk("ld_isload_at_we", load_at_we[7:0], 8'd1);
      chk("ld_pc_after", pc_after_ld, 8'h51);

      // ST completes in one MEM cycle
      tick(1);
      chk("st_dreq", dmem_req, 1);
      chk("st_we", dmem_we, 1);
      chk("st_addr", dmem_addr, 8'h33);
      chk("st_wdata", dmem_wdata, 8'hA7);
      chk("st_no_regwe", write_en, 0);
      tick(1);
      chk("st_pc_after", pc, 8'h52);

      // Fetch stall on imem_ready low
      imem_ready = 1'b0;
      tick(2);
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, 8'h52);
      imem_ready = 1'b1;

      // JMP 0xFF then LDI at 0xFF wraps the pc
      tick(3);
      chk("jmp_pc", pc, 8'hFF);
      tick(3);
      chk("wrap_addr", imem_addr, 8'h00);
      chk("wrap_pc", pc, 8'h00);

      // Second pass with Z=C=0; pause raised during ADD EXEC
      alu_zero = 1'b0;
      alu_carry = 1'b0;
      tick(6);
      tick(2);
      pause = 1'b1;
      chk("pause_add_we", write_en, 1);
      tick(1);
      chk("pause_req", imem_req, 0);
      chk("pause_paused", cpu_paused, 1);
      chk("pause_pc", pc, 8'h03);
      tick(2);
      chk("pause_hold_pc", pc, 8'h03);
      chk("pause_hold_req", imem_req, 0);
      pause = 1'b0;
      #1;
      chk("unpause_req", imem_req, 1);
      chk("unpause_paused", cpu_paused, 0);
      tick(3);
      chk("bz_not_taken_pc", pc, 8'h04);

      // HLT is terminal
      tick(3);
      chk("halt_halted", halted, 1);
      chk("halt_paused", cpu_paused, 1);
      tick(5);
      chk("halt_stays", halted, 1);
      chk("halt_no_fetch", imem_req, 0);

      // Reset while an LD waits in MEM
      rst_n = 1'b0;
      #1;
      chk("rst_clears_halt", halted, 0);
      imem[8'h01] = 16'h9510;
      dmem_ready = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(6);
      chk("mem_pending_req", dmem_req, 1);
      chk("mem_pending_pc", pc, 8'h01);
      chk("mem_pending_isload", is_load, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_dreq", dmem_req, 0);
      chk("async_rst_isload", is_load, 0);
      chk("async_rst_waddr", write_addr, 4'd0);
      chk("async_rst_pc", pc, 8'h00);
      chk("async_rst_imem_req", imem_req, 0);
      tick(1);
      rst_n = 1'b1;
      #1;
      chk("refetch_addr", imem_addr, 8'h00);
      chk("refetch_req", imem_req, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
